// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: latches a hex word via valid/ready and scans it
// one digit at a time onto a seven-segment decoder with guard gaps and lz blanking.
//
// state | meaning
// EMPTY | no word held, all digits off, ready for a word
// DRIVE | digit idx enabled (unless blanked) for REFRESH_DIV cycles
// GUARD | all digits off for GUARD_CYCLES cycles, nibble held

module hex_display_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_DIGITS-1:0] in_data,
   input  logic                    lz_blank,
   output logic [3:0]              nibble,
   output logic [NUM_DIGITS-1:0]   digit_en_n
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_R_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int CNT_G_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam int CNT_W   = (CNT_R_W > CNT_G_W) ? CNT_R_W : CNT_G_W;

   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      DRIVE = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d, blank_new;
   logic [3:0]              nibble_d;
   logic [NUM_DIGITS-1:0]   en_d;
   logic                    last_digit;
   logic                    frame_end;
   logic                    accept;
   logic                    zeros_above;

   assign last_digit = (idx_q == IDX_LAST);
   assign idx_next   = last_digit ? '0 : idx_q + IDX_W'(1);

   // Without guard cycles the frame closes on the last DRIVE cycle of the top digit.
   always_comb begin
      frame_end = 1'b0;
      if (GUARD_CYCLES == 0)
         frame_end = (state_q == DRIVE) && last_digit && (cnt_q == DRIVE_LAST);
      else
         frame_end = (state_q == GUARD) && last_digit && (cnt_q == GUARD_LAST);
   end

   assign in_ready = (state_q == EMPTY) || frame_end;
   assign accept   = in_valid && in_ready && !clear;

   // Digit i blanks when it and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      zeros_above = 1'b1;
      blank_new   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zeros_above  = zeros_above && (in_data[4*i +: 4] == 4'h0);
         blank_new[i] = lz_blank && zeros_above;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      blank_d  = blank_q;
      nibble_d = nibble;
      en_d     = '1;

      unique case (state_q)
         EMPTY: ;
         DRIVE: begin
            if (cnt_q == DRIVE_LAST) begin
               cnt_d = '0;
               if (GUARD_CYCLES == 0) begin
                  idx_d = idx_next;
               end else begin
                  state_d = GUARD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               cnt_d   = '0;
               state_d = DRIVE;
               idx_d   = idx_next;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         state_d = DRIVE;
         idx_d   = '0;
         cnt_d   = '0;
         data_d  = in_data;
         blank_d = blank_new;
      end

      if (clear) begin
         state_d  = EMPTY;
         idx_d    = '0;
         cnt_d    = '0;
         data_d   = '0;
         blank_d  = '0;
      end

      // Outputs are registered from the next state so they line up with it.
      if (state_d == DRIVE) begin
         nibble_d    = data_d[4*idx_d +: 4];
         en_d[idx_d] = blank_d[idx_d];
      end
      if (clear)
         nibble_d = 4'h0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         idx_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         blank_q    <= '0;
         nibble     <= 4'h0;
         digit_en_n <= '1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         blank_q    <= blank_d;
         nibble     <= nibble_d;
         digit_en_n <= en_d;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: table-driven frames checked through
// a scoreboard queue, plus hand sequences for hold, clear, async reset and no-guard mode.

module tb_hex_display_scanner;

   localparam int ND = 4;
   localparam int RD = 3;
   localparam int GC = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          lz_blank = 1'b0;
   logic [15:0]   in_data = '0;
   logic          in_ready, in_ready0;
   logic [3:0]    nibble, nibble0;
   logic [3:0]    en, en0;

   always #5 clk = ~clk;

   hex_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .lz_blank(lz_blank), .nibble(nibble), .digit_en_n(en)
   );

   hex_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .lz_blank(lz_blank), .nibble(nibble0), .digit_en_n(en0)
   );

   typedef struct {
      logic [3:0] en;
      logic [3:0] nib;
      logic       rdy;
   } exp_t;

   typedef struct {
      logic [15:0] data;
      logic        lz;
      logic [3:0]  vis;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;
   bit   use0 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   // Expected per-cycle outputs for nfr frames; vis[d]=1 means digit d lights.
   task automatic push_frames(input logic [15:0] d, input logic [3:0] vis, input int g,
                              input int nfr);
      exp_t       e;
      logic [3:0] oh;
      for (int f = 0; f < nfr; f++) begin
         for (int dg = 0; dg < ND; dg++) begin
            oh = 4'b0001 << dg;
            for (int c = 0; c < RD; c++) begin
               e.en  = vis[dg] ? ~oh : 4'hF;
               e.nib = d[4*dg +: 4];
               e.rdy = (g == 0) && (dg == ND - 1) && (c == RD - 1);
               sb.push_back(e);
            end
            for (int c = 0; c < g; c++) begin
               e.en  = 4'hF;
               e.nib = d[4*dg +: 4];
               e.rdy = (dg == ND - 1) && (c == g - 1);
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic run_stream(input int drop_at, input string tag);
      exp_t e;
      int   j = 0;
      while (sb.size() > 0) begin
         if (j == drop_at) in_valid = 1'b0;
         e = sb.pop_front();
         chk({tag, "_en"},  use0 ? en0 : en, e.en);
         chk({tag, "_nib"}, use0 ? nibble0 : nibble, e.nib);
         chk({tag, "_rdy"}, use0 ? in_ready0 : in_ready, e.rdy);
         j++;
         @(negedge clk);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic do_accept(input logic [15:0] d, input logic lz);
      in_data  = d;
      lz_blank = lz;
      in_valid = 1'b1;
      chk("accept_rdy", use0 ? in_ready0 : in_ready, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{16'h1A2F, 1'b0, 4'b1111};
      vecs[1] = '{16'h00B0, 1'b1, 4'b0011};
      vecs[2] = '{16'h0000, 1'b1, 4'b0001};
      vecs[3] = '{16'h0000, 1'b0, 4'b1111};
      vecs[4] = '{16'h0100, 1'b1, 4'b0111};
      vecs[5] = '{16'hF000, 1'b1, 4'b1111};
      vecs[6] = '{16'h000F, 1'b1, 4'b0001};

      @(negedge clk);
      chk("rst_en", en, 4'hF);
      chk("rst_nib", nibble, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         chk("idle_en", en, 4'hF);
         chk("idle_nib", nibble, 4'h0);
         chk("idle_rdy", in_ready, 1'b1);
         chk("idle_rdy0", in_ready0, 1'b1);
         chk("idle_en0", en0, 4'hF);
         @(negedge clk);
      end

      foreach (vecs[k]) begin
         do_clear();
         do_accept(vecs[k].data, vecs[k].lz);
         push_frames(vecs[k].data, vecs[k].vis, GC, 2);
         run_stream(0, "vec");
      end

      // Word held mid-frame is taken only at frame end.
      do_clear();
      do_accept(16'h1A2F, 1'b0);
      in_data = 16'h5555;
      push_frames(16'h1A2F, 4'b1111, GC, 1);
      push_frames(16'h5555, 4'b1111, GC, 1);
      run_stream(16, "hold");

      // Clear during digit 2 drive with a word offered.
      do_clear();
      do_accept(16'h1A2F, 1'b0);
      push_frames(16'h1A2F, 4'b1111, GC, 1);
      while (sb.size() > 9) sb.delete(sb.size() - 1);
      run_stream(0, "pre_clr");
      chk("clr_pre_en", en, 4'b1011);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h5555;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_en", en, 4'hF);
      chk("clr_rdy", in_ready, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_noacc_en", en, 4'hF);
      chk("clr_noacc_rdy", in_ready, 1'b1);

      // Asynchronous reset during a guard slot.
      do_clear();
      do_accept(16'h1A2F, 1'b0);
      push_frames(16'h1A2F, 4'b1111, GC, 1);
      while (sb.size() > 3) sb.delete(sb.size() - 1);
      run_stream(0, "pre_rst");
      chk("guard_en", en, 4'hF);
      chk("guard_nib", nibble, 4'hF);
      chk("guard_rdy", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_en", en, 4'hF);
      chk("arst_nib", nibble, 4'h0);
      chk("arst_rdy", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_en", en, 4'hF);
      chk("post_rst_rdy", in_ready, 1'b1);

      // No-guard instance: 12-cycle frames, digits back to back.
      use0 = 1'b1;
      do_clear();
      do_accept(16'h1A2F, 1'b0);
      push_frames(16'h1A2F, 4'b1111, 0, 2);
      run_stream(0, "g0");
      do_clear();
      do_accept(16'h00B0, 1'b1);
      push_frames(16'h00B0, 4'b0011, 0, 1);
      run_stream(0, "g0_lz");
      use0 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
